// File: rtl/wm_us_echo_gen_if.sv
// Trig/echo link between the ultrasonic controller (master) and the
// sensor emulator (slave), plus the emulator's status strobes.
interface wm_us_echo_gen_if;
    logic [7:0] distCm;
    logic       usTrig;
    logic       usEcho;
    logic       busy;
    logic       trigErr;
    logic       echoDone;

    modport master (
        output distCm,
        output usTrig,
        input  usEcho,
        input  busy,
        input  trigErr,
        input  echoDone
    );

    modport slave (
        input  distCm,
        input  usTrig,
        output usEcho,
        output busy,
        output trigErr,
        output echoDone
    );
endinterface

// File: rtl/wm_us_echo_gen.sv
// HC-SR04 ultrasonic sensor emulator. A trigger pulse of at least
// TRIG_MIN_US is answered, ECHO_DELAY_US later, by an echo pulse whose
// width is distCm*US_PER_CM us (TIMEOUT_US when distCm is 0), followed by
// a HOLDOFF_US dead time. All durations are whole microseconds of
// CNT_1USEC clocks, timed from the entry of each state.
// Optional feature: define WM_US_JITTER_EN to add 0..7 us of LFSR jitter
// to every echo width.
module wm_us_echo_gen #(
    parameter int CNT_1USEC     = 125,
    parameter int TRIG_MIN_US   = 10,
    parameter int ECHO_DELAY_US = 250,
    parameter int US_PER_CM     = 58,
    parameter int TIMEOUT_US    = 38000,
    parameter int HOLDOFF_US    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    wm_us_echo_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_DELAY,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [15:0] r_pre;
    logic [15:0] r_us;
    logic [15:0] r_width;
    logic        r_echo;
    logic        r_busy;
    logic        r_trig_err;
    logic        r_echo_done;

    logic        w_rise;
    logic        w_fall;
    logic        w_tick;
    logic        w_last;
    logic        w_accept;
    logic [15:0] w_target;
    logic [15:0] w_base;
    logic [15:0] w_width_next;

    assign w_rise   = r_sync2 & ~r_sync3;
    assign w_fall   = ~r_sync2 & r_sync3;
    assign w_tick   = (r_pre == 16'(CNT_1USEC - 1));
    assign w_last   = w_tick && (r_us == w_target - 16'd1);
    assign w_accept = (r_state == S_TRIG_HI) && w_fall && (r_us >= 16'(TRIG_MIN_US));

    // Product fits in 16 bits for any 8-bit distance
    assign w_base = (bus.distCm == 8'd0) ? 16'(TIMEOUT_US)
                                         : ({8'd0, bus.distCm} * 16'(US_PER_CM));

`ifdef WM_US_JITTER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_width_next = w_base + {13'd0, r_lfsr[2:0]};

    // Jitter source advances once per accepted trigger
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_width_next = w_base;
`endif

    // Duration of the current timed state, in us
    always_comb begin
        w_target = 16'd1;
        case (r_state)
            S_DELAY:   w_target = 16'(ECHO_DELAY_US);
            S_ECHO:    w_target = r_width;
            S_HOLDOFF: w_target = 16'(HOLDOFF_US);
            default:   w_target = 16'd1;
        endcase
    end

    // Trigger synchronizer, us timebase and sequencing FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_pre       <= 16'd0;
            r_us        <= 16'd0;
            r_width     <= 16'd0;
            r_echo      <= 1'b0;
            r_busy      <= 1'b0;
            r_trig_err  <= 1'b0;
            r_echo_done <= 1'b0;
        end else begin
            r_sync1     <= bus.usTrig;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_trig_err  <= 1'b0;
            r_echo_done <= 1'b0;

            if (w_tick) begin
                r_pre <= 16'd0;
                if (r_us != 16'hFFFF) begin
                    r_us <= r_us + 16'd1;
                end
            end else begin
                r_pre <= r_pre + 16'd1;
            end

            // Every state change restarts the timebase (overrides the above)
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_TRIG_HI;
                        r_busy  <= 1'b1;
                        r_pre   <= 16'd0;
                        r_us    <= 16'd0;
                    end
                end
                S_TRIG_HI: begin
                    if (w_fall) begin
                        r_pre <= 16'd0;
                        r_us  <= 16'd0;
                        if (w_accept) begin
                            r_state <= S_DELAY;
                            r_width <= w_width_next;
                        end else begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_trig_err <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (w_last) begin
                        r_state <= S_ECHO;
                        r_echo  <= 1'b1;
                        r_pre   <= 16'd0;
                        r_us    <= 16'd0;
                    end
                end
                S_ECHO: begin
                    if (w_last) begin
                        r_state     <= S_HOLDOFF;
                        r_echo      <= 1'b0;
                        r_echo_done <= 1'b1;
                        r_pre       <= 16'd0;
                        r_us        <= 16'd0;
                    end
                end
                S_HOLDOFF: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pre   <= 16'd0;
                        r_us    <= 16'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_echo  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.usEcho   = r_echo;
    assign bus.busy     = r_busy;
    assign bus.trigErr  = r_trig_err;
    assign bus.echoDone = r_echo_done;

endmodule

// File: tb/tb_wm_us_echo_gen.sv
// Directed bench for wm_us_echo_gen with a shortened timebase:
// 2 clk/us, 25 us delay, 100 us holdoff, 300 us timeout.
module tb_wm_us_echo_gen;

    localparam int CNT   = 2;
    localparam int DLY   = 25;
    localparam int HOLD  = 100;
    localparam int TOUT  = 300;

    logic clk = 1'b0;
    logic reset;

    wm_us_echo_gen_if bus();

    wm_us_echo_gen #(
        .CNT_1USEC     (CNT),
        .TRIG_MIN_US   (10),
        .ECHO_DELAY_US (DLY),
        .US_PER_CM     (58),
        .TIMEOUT_US    (TOUT),
        .HOLDOFF_US    (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Echo monitor: width in clocks, falls, strobe counts
    int cur_len      = 0;
    int last_len     = 0;
    int n_echo       = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int done_at_fall = 0;
    logic prev_echo  = 1'b0;

    always @(negedge clk) begin
        if (bus.usEcho) begin
            cur_len = cur_len + 1;
        end else if (prev_echo) begin
            last_len     = cur_len;
            cur_len      = 0;
            n_echo       = n_echo + 1;
            done_at_fall = int'(bus.echoDone);
        end
        if (bus.echoDone) done_cnt = done_cnt + 1;
        if (bus.trigErr)  err_cnt  = err_cnt + 1;
        prev_echo = bus.usEcho;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic trig(input int n);
        bus.usTrig = 1'b1;
        repeat (n) step();
        bus.usTrig = 1'b0;
    endtask

    task automatic wait_rise(input string tag, output int k);
        k = 0;
        while (!bus.usEcho && k < 300) begin
            step();
            k++;
        end
        check(tag, int'(bus.usEcho), 1);
    endtask

    task automatic wait_echo(input string tag, input int target, input int budget);
        int k = 0;
        while (n_echo < target && k < budget) begin
            step();
            k++;
        end
        check(tag, int'(n_echo >= target), 1);
    endtask

    task automatic wait_idle(input string tag, output int k);
        k = 0;
        while (bus.busy && k < 1000) begin
            step();
            k++;
        end
        check(tag, int'(bus.busy), 0);
    endtask

    initial begin
        int k;
        int wmin;
        int wmax;
        reset      = 1'b1;
        bus.usTrig = 1'b0;
        bus.distCm = 8'd0;
        repeat (3) step();
        check("rst_echo", int'(bus.usEcho), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.trigErr), 0);
        check("rst_done", int'(bus.echoDone), 0);
        reset = 1'b0;
        repeat (5) step();

        // 1: 10 cm, 12 us trigger -> 580 us echo after 25 us delay
        bus.distCm = 8'd10;
        trig(12 * CNT);
        wait_rise("t1_rise", k);
        check("t1_latency", k, 3 + DLY * CNT);
        check("t1_busy", int'(bus.busy), 1);
        wait_echo("t1_end", 1, 3000);
        check("t1_width", last_len, 580 * CNT);
        check("t1_done_at_fall", done_at_fall, 1);
        check("t1_done_cnt", done_cnt, 1);
        wait_idle("t1_idle", k);
        check("t1_holdoff", k, HOLD * CNT);
        check("t1_no_err", err_cnt, 0);

        // 2: 5 us trigger is rejected with a single 1-clk error pulse
        repeat (5) step();
        trig(5 * CNT);
        repeat (10) step();
        check("t2_err", err_cnt, 1);
        check("t2_busy", int'(bus.busy), 0);
        repeat (100) step();
        check("t2_no_echo", n_echo, 1);

        // 3: no object -> timeout width
        bus.distCm = 8'd0;
        trig(12 * CNT);
        wait_echo("t3_end", 2, 2000);
        check("t3_width", last_len, TOUT * CNT);
        wait_idle("t3_idle", k);

        // 4: triggers during ECHO, mid HOLDOFF, and held across IDLE return
        repeat (5) step();
        bus.distCm = 8'd10;
        trig(12 * CNT);
        wait_rise("t4_rise", k);
        repeat (100) step();
        trig(12 * CNT);
        wait_echo("t4_end", 3, 3000);
        check("t4_width", last_len, 580 * CNT);
        repeat (100) step();
        trig(12 * CNT);
        repeat (40) step();
        bus.usTrig = 1'b1;
        repeat (95) step();
        bus.usTrig = 1'b0;
        repeat (150) step();
        check("t4_ignored_echo", n_echo, 3);
        check("t4_ignored_err", err_cnt, 1);
        check("t4_idle", int'(bus.busy), 0);
        trig(12 * CNT);
        wait_echo("t4_next_end", 4, 3000);
        check("t4_next_width", last_len, 580 * CNT);
        wait_idle("t4_next_idle", k);

        // 5: distance change during DELAY is not seen by the echo
        repeat (5) step();
        bus.distCm = 8'd20;
        trig(12 * CNT);
        repeat (10) step();
        bus.distCm = 8'd200;
        wait_echo("t5_end", 5, 6000);
        check("t5_width", last_len, 1160 * CNT);
        wait_idle("t5_idle", k);

        // 5b: reset mid-echo drops usEcho next clock without echoDone
        repeat (5) step();
        bus.distCm = 8'd20;
        trig(12 * CNT);
        wait_rise("t5b_rise", k);
        repeat (50) step();
        reset = 1'b1;
        step();
        check("t5b_echo", int'(bus.usEcho), 0);
        check("t5b_done", int'(bus.echoDone), 0);
        check("t5b_busy", int'(bus.busy), 0);
        check("t5b_done_at_fall", done_at_fall, 0);
        reset = 1'b0;
        repeat (5) step();
        check("t5b_done_cnt", done_cnt, 5);
        bus.distCm = 8'd10;
        trig(12 * CNT);
        wait_echo("t5b_recover_end", 7, 3000);
        check("t5b_recover_width", last_len, 580 * CNT);
        wait_idle("t5b_recover_idle", k);

`ifdef WM_US_JITTER_EN
        // 6: jitter keeps widths within +0..7 us and varies them
        wmin = 32'h7fffffff;
        wmax = 0;
        bus.distCm = 8'd10;
        for (int i = 0; i < 16; i++) begin
            repeat (5) step();
            trig(12 * CNT);
            wait_echo("t6_end", 8 + i, 3000);
            check("t6_range", int'(last_len >= 580 * CNT && last_len <= 587 * CNT
                                   && (last_len % CNT) == 0), 1);
            if (last_len < wmin) wmin = last_len;
            if (last_len > wmax) wmax = last_len;
            wait_idle("t6_idle", k);
        end
        check("t6_distinct", int'(wmax != wmin), 1);
`else
        wmin = 0;
        wmax = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
